mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port cache-line arbiter. Grants one cache port at a time to a
// single-beat memory interface and walks BEATS words of a 64-byte line,
// either filling (read) or writing back (write). Ties between the ports
// are broken round-robin, starting with port 0 after reset.
module mem_arbiter #(
   parameter int BEATS = 16
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [3:0]  beat_idx,
   output logic [31:0] rdata,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic        done0,
   output logic        done1,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        winner_q, winner_d;   // 0 = port 0 owns the transaction
   logic        we_q, we_d;
   logic        last_q, last_d;       // port served most recently
   logic [25:0] base_q, base_d;       // line address, bits [31:6]
   logic [3:0]  beat_q, beat_d;

   // The low six address bits select a byte within the line and are dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr0[5:0], addr1[5:0]};

   logic last_beat;
   assign last_beat = (beat_q == 4'(BEATS - 1));

   // State and transaction registers; reset aborts any burst in progress.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= IDLE;
         winner_q <= 1'b0;
         we_q     <= 1'b0;
         last_q   <= 1'b1;            // port 0 wins the first tie
         base_q   <= '0;
         beat_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so ordering of these lines does not matter.
         state_q  <= state_d;
         winner_q <= winner_d;
         we_q     <= we_d;
         last_q   <= last_d;
         base_q   <= base_d;
         beat_q   <= beat_d;
      end
   end

   // Next-state logic and all outputs, derived from the registered state.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      winner_d  = winner_q;
      we_d      = we_q;
      last_d    = last_q;
      base_d    = base_q;
      beat_d    = beat_q;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      rdata     = '0;
      done0     = 1'b0;
      done1     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the port not served last wins.
               winner_d = (req0 && req1) ? ~last_q : req1;
               we_d     = winner_d ? we1 : we0;
               base_d   = winner_d ? addr1[31:6] : addr0[31:6];
               beat_d   = '0;
               state_d  = XFER;
            end
         end

         XFER: begin
            gnt0      = ~winner_q;
            gnt1      = winner_q;
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {base_q, 6'b0} + {26'b0, beat_q, 2'b00};
            mem_wdata = we_q ? (winner_q ? wdata1 : wdata0) : '0;
            if (mem_ack) begin
               if (!we_q) begin
                  rdata   = mem_rdata;
                  rvalid0 = ~winner_q;
                  rvalid1 = winner_q;
               end
               // The last beat holds its index rather than wrapping.
               if (last_beat) state_d = DONE;
               else           beat_d  = 4'(beat_q + 4'd1);
            end
         end

         DONE: begin
            gnt0    = ~winner_q;
            gnt1    = winner_q;
            done0   = ~winner_q;
            done1   = winner_q;
            last_d  = winner_q;
            beat_d  = '0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign beat_idx = beat_q;

endmodule
